// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue.
//   OPC_LOAD / OPC_STORE : memory opcodes recognised by the queue
//   UOP_W / FUNC_W / DATA_W : entry field widths
//   uop_ready()          : operand-readiness rule for one uop
package mem_issue_queue_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int unsigned UOP_W  = 7;
  localparam int unsigned FUNC_W = 10;
  localparam int unsigned DATA_W = 32;

  // Stores need base and data; everything else only needs the base operand.
  function automatic logic uop_ready(input logic [UOP_W-1:0] uop,
                                     input logic             rdy1,
                                     input logic             rdy2);
    return (uop == OPC_STORE) ? (rdy1 & rdy2) : rdy1;
  endfunction

endpackage

// File: rtl/memq_entry.sv
// One slot of the memory issue queue.
// Holds the uop fields, snoops the writeback broadcast to capture pending
// operands, and reports when the slot is occupied and ready to issue.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_clr               flush: drop the slot
//   i_wr                write dispatch fields (already wakeup-resolved)
//   i_pop               slot issued this cycle
//   i_uop..i_imm        dispatch fields
//   i_wb_*              writeback broadcast
//   o_ready             slot valid and its required operands are present
//   o_uop..o_imm        stored fields for the issue mux
module memq_entry
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned WIDTH_REG = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr,
  input  logic                 i_pop,
  input  logic [UOP_W-1:0]     i_uop,
  input  logic [FUNC_W-1:0]    i_func,
  input  logic [WIDTH_REG-1:0] i_rd,
  input  logic [WIDTH_REG-1:0] i_rs1,
  input  logic                 i_rdy1,
  input  logic [DATA_W-1:0]    i_op1,
  input  logic [WIDTH_REG-1:0] i_rs2,
  input  logic                 i_rdy2,
  input  logic [DATA_W-1:0]    i_op2,
  input  logic [DATA_W-1:0]    i_imm,
  input  logic                 i_wb_valid,
  input  logic [WIDTH_REG-1:0] i_wb_tag,
  input  logic [DATA_W-1:0]    i_wb_data,
  output logic                 o_ready,
  output logic [UOP_W-1:0]     o_uop,
  output logic [FUNC_W-1:0]    o_func,
  output logic [WIDTH_REG-1:0] o_rd,
  output logic [DATA_W-1:0]    o_op1,
  output logic [DATA_W-1:0]    o_op2,
  output logic [DATA_W-1:0]    o_imm
);

  logic                 r_valid;
  logic [UOP_W-1:0]     r_uop;
  logic [FUNC_W-1:0]    r_func;
  logic [WIDTH_REG-1:0] r_rd;
  logic [WIDTH_REG-1:0] r_rs1;
  logic                 r_rdy1;
  logic [DATA_W-1:0]    r_op1;
  logic [WIDTH_REG-1:0] r_rs2;
  logic                 r_rdy2;
  logic [DATA_W-1:0]    r_op2;
  logic [DATA_W-1:0]    r_imm;

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = r_valid && !r_rdy1 && i_wb_valid && (i_wb_tag == r_rs1);
  assign w_hit2 = r_valid && !r_rdy2 && i_wb_valid && (i_wb_tag == r_rs2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_uop   <= '0;
      r_func  <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rdy1  <= 1'b0;
      r_op1   <= '0;
      r_rs2   <= '0;
      r_rdy2  <= 1'b0;
      r_op2   <= '0;
      r_imm   <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_uop   <= i_uop;
      r_func  <= i_func;
      r_rd    <= i_rd;
      r_rs1   <= i_rs1;
      r_rdy1  <= i_rdy1;
      r_op1   <= i_op1;
      r_rs2   <= i_rs2;
      r_rdy2  <= i_rdy2;
      r_op2   <= i_op2;
      r_imm   <= i_imm;
    end else begin
      if (i_pop) r_valid <= 1'b0;
      if (w_hit1) begin
        r_op1  <= i_wb_data;
        r_rdy1 <= 1'b1;
      end
      if (w_hit2) begin
        r_op2  <= i_wb_data;
        r_rdy2 <= 1'b1;
      end
    end
  end

  assign o_ready = r_valid && uop_ready(r_uop, r_rdy1, r_rdy2);
  assign o_uop   = r_uop;
  assign o_func  = r_func;
  assign o_rd    = r_rd;
  assign o_op1   = r_op1;
  assign o_op2   = r_op2;
  assign o_imm   = r_imm;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue for load/store uops feeding the memory stage.
// Circular buffer of 2^DEPTH_W slots; only the head may issue, which keeps
// memory accesses in program order. Outputs are registered, single-cycle
// o_valid pulses with no backpressure.
// Optional build macro MEMQ_BYPASS_EN: a ready uop dispatched into an empty
// queue goes straight to the output registers (one cycle earlier).
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_flush                   drop all entries and any pending issue
//   i_dis_valid/o_dis_ready   dispatch handshake
//   i_uop..i_imm              dispatched uop, tags and operands
//   i_wb_valid/tag/data       writeback broadcast for operand wakeup
//   o_valid..o_imm            issued uop to the memory stage
//   o_count                   occupied entries
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 3,
  parameter int unsigned WIDTH_REG = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_dis_valid,
  output logic                 o_dis_ready,
  input  logic [UOP_W-1:0]     i_uop,
  input  logic [FUNC_W-1:0]    i_func,
  input  logic [WIDTH_REG-1:0] i_rd,
  input  logic [WIDTH_REG-1:0] i_rs1,
  input  logic                 i_rs1_rdy,
  input  logic [DATA_W-1:0]    i_op1,
  input  logic [WIDTH_REG-1:0] i_rs2,
  input  logic                 i_rs2_rdy,
  input  logic [DATA_W-1:0]    i_op2,
  input  logic [DATA_W-1:0]    i_imm,
  input  logic                 i_wb_valid,
  input  logic [WIDTH_REG-1:0] i_wb_tag,
  input  logic [DATA_W-1:0]    i_wb_data,
  output logic                 o_valid,
  output logic [UOP_W-1:0]     o_uop,
  output logic [FUNC_W-1:0]    o_func,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic [DATA_W-1:0]    o_op1,
  output logic [DATA_W-1:0]    o_op2,
  output logic [DATA_W-1:0]    o_imm,
  output logic [DEPTH_W:0]     o_count
);

  localparam int unsigned      DEPTH     = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH_W-1:0] r_head;
  logic [DEPTH_W-1:0] r_tail;
  logic [DEPTH_W:0]   r_count;

  logic                 r_valid;
  logic [UOP_W-1:0]     r_uop;
  logic [FUNC_W-1:0]    r_func;
  logic [WIDTH_REG-1:0] r_addr;
  logic [DATA_W-1:0]    r_op1;
  logic [DATA_W-1:0]    r_op2;
  logic [DATA_W-1:0]    r_imm;

  logic                 w_dis_ready;
  logic                 w_dis_acc;
  logic                 w_hit1;
  logic                 w_hit2;
  logic                 w_dis_rdy1;
  logic                 w_dis_rdy2;
  logic [DATA_W-1:0]    w_dis_op1;
  logic [DATA_W-1:0]    w_dis_op2;
  logic                 w_issue;
  logic                 w_bypass;
  logic                 w_write;

  logic [DEPTH-1:0]     w_e_ready;
  logic [UOP_W-1:0]     w_e_uop [DEPTH];
  logic [FUNC_W-1:0]    w_e_func[DEPTH];
  logic [WIDTH_REG-1:0] w_e_rd  [DEPTH];
  logic [DATA_W-1:0]    w_e_op1 [DEPTH];
  logic [DATA_W-1:0]    w_e_op2 [DEPTH];
  logic [DATA_W-1:0]    w_e_imm [DEPTH];

  // Registered count only: an issue in the same cycle does not open a slot.
  assign w_dis_ready = (r_count != DEPTH_CNT);
  assign w_dis_acc   = i_dis_valid && w_dis_ready;

  // Resolve a broadcast that lands in the dispatch cycle before storing.
  assign w_hit1     = i_wb_valid && (i_wb_tag == i_rs1) && !i_rs1_rdy;
  assign w_hit2     = i_wb_valid && (i_wb_tag == i_rs2) && !i_rs2_rdy;
  assign w_dis_rdy1 = i_rs1_rdy || w_hit1;
  assign w_dis_rdy2 = i_rs2_rdy || w_hit2;
  assign w_dis_op1  = w_hit1 ? i_wb_data : i_op1;
  assign w_dis_op2  = w_hit2 ? i_wb_data : i_op2;

  assign w_issue = (r_count != '0) && w_e_ready[r_head];

`ifdef MEMQ_BYPASS_EN
  // Empty queue implies no issue is pending this cycle.
  assign w_bypass = w_dis_acc && (r_count == '0) &&
                    uop_ready(i_uop, w_dis_rdy1, w_dis_rdy2);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_write = w_dis_acc && !w_bypass;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    memq_entry #(
      .WIDTH_REG (WIDTH_REG)
    ) u_entry (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (i_flush),
      .i_wr       (w_write && (r_tail == DEPTH_W'(g))),
      .i_pop      (w_issue && (r_head == DEPTH_W'(g))),
      .i_uop      (i_uop),
      .i_func     (i_func),
      .i_rd       (i_rd),
      .i_rs1      (i_rs1),
      .i_rdy1     (w_dis_rdy1),
      .i_op1      (w_dis_op1),
      .i_rs2      (i_rs2),
      .i_rdy2     (w_dis_rdy2),
      .i_op2      (w_dis_op2),
      .i_imm      (i_imm),
      .i_wb_valid (i_wb_valid),
      .i_wb_tag   (i_wb_tag),
      .i_wb_data  (i_wb_data),
      .o_ready    (w_e_ready[g]),
      .o_uop      (w_e_uop[g]),
      .o_func     (w_e_func[g]),
      .o_rd       (w_e_rd[g]),
      .o_op1      (w_e_op1[g]),
      .o_op2      (w_e_op2[g]),
      .o_imm      (w_e_imm[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) r_tail <= r_tail + DEPTH_W'(1);
      if (w_issue) r_head <= r_head + DEPTH_W'(1);
      case ({w_write, w_issue})
        2'b10:   r_count <= r_count + (DEPTH_W+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue data holds its last value while o_valid is low.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_valid <= 1'b0;
      r_uop   <= '0;
      r_func  <= '0;
      r_addr  <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_uop   <= w_e_uop[r_head];
      r_func  <= w_e_func[r_head];
      r_addr  <= w_e_rd[r_head];
      r_op1   <= w_e_op1[r_head];
      r_op2   <= w_e_op2[r_head];
      r_imm   <= w_e_imm[r_head];
    end else if (w_bypass) begin
      r_valid <= 1'b1;
      r_uop   <= i_uop;
      r_func  <= i_func;
      r_addr  <= i_rd;
      r_op1   <= w_dis_op1;
      r_op2   <= w_dis_op2;
      r_imm   <= i_imm;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_dis_ready = w_dis_ready;
  assign o_count     = r_count;
  assign o_valid     = r_valid;
  assign o_uop       = r_uop;
  assign o_func      = r_func;
  assign o_addr      = r_addr;
  assign o_op1       = r_op1;
  assign o_op2       = r_op2;
  assign o_imm       = r_imm;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: a queue-based reference model is
// compared against the DUT every cycle, with directed scenarios pinning
// latency, ordering, full/wrap and flush to literal values, then random traffic.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, dis_valid, dis_ready;
  logic [6:0]  uop;
  logic [9:0]  func;
  logic [4:0]  rd, rs1, rs2, wb_tag, o_addr;
  logic        rs1_rdy, rs2_rdy, wb_valid, o_valid;
  logic [31:0] op1, op2, imm, wb_data, o_op1, o_op2, o_imm;
  logic [6:0]  o_uop;
  logic [9:0]  o_func;
  logic [3:0]  o_count;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH_W(3), .WIDTH_REG(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_dis_valid(dis_valid), .o_dis_ready(dis_ready),
    .i_uop(uop), .i_func(func), .i_rd(rd),
    .i_rs1(rs1), .i_rs1_rdy(rs1_rdy), .i_op1(op1),
    .i_rs2(rs2), .i_rs2_rdy(rs2_rdy), .i_op2(op2), .i_imm(imm),
    .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_data(wb_data),
    .o_valid(o_valid), .o_uop(o_uop), .o_func(o_func), .o_addr(o_addr),
    .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm), .o_count(o_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]  uop;
    logic [9:0]  func;
    logic [4:0]  rd, rs1, rs2;
    bit          rdy1, rdy2;
    logic [31:0] op1, op2, imm;
  } ent_t;

  ent_t        mq[$];
  bit          m_valid;
  logic [6:0]  m_uop;
  logic [9:0]  m_func;
  logic [4:0]  m_rd;
  logic [31:0] m_op1, m_op2, m_imm;

  function automatic bit m_ready(ent_t e);
    if (e.uop == OPC_STORE) return e.rdy1 && e.rdy2;
    return e.rdy1;
  endfunction

  function automatic void m_load_out(ent_t e);
    m_uop = e.uop; m_func = e.func; m_rd = e.rd;
    m_op1 = e.op1; m_op2 = e.op2; m_imm = e.imm;
  endfunction

  always @(posedge clk) begin : model
    ent_t ne, h;
    bit   iss, acc, byp;
    if (!rst_n || flush) begin
      mq.delete();
      m_valid = 0; m_uop = 0; m_func = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_imm = 0;
    end else begin
      iss = (mq.size() != 0) && m_ready(mq[0]);
      acc = dis_valid && (mq.size() != 8);
      ne.uop = uop; ne.func = func; ne.rd = rd; ne.imm = imm;
      ne.rs1 = rs1; ne.rs2 = rs2;
      ne.rdy1 = rs1_rdy || (wb_valid && wb_tag == rs1);
      ne.op1  = (!rs1_rdy && wb_valid && wb_tag == rs1) ? wb_data : op1;
      ne.rdy2 = rs2_rdy || (wb_valid && wb_tag == rs2);
      ne.op2  = (!rs2_rdy && wb_valid && wb_tag == rs2) ? wb_data : op2;
      byp = 0;
`ifdef MEMQ_BYPASS_EN
      byp = acc && (mq.size() == 0) && m_ready(ne);
`endif
      // Issue takes the head's pre-edge contents.
      if (iss) h = mq.pop_front();
      foreach (mq[k]) begin
        if (wb_valid && !mq[k].rdy1 && mq[k].rs1 == wb_tag) begin
          mq[k].rdy1 = 1; mq[k].op1 = wb_data;
        end
        if (wb_valid && !mq[k].rdy2 && mq[k].rs2 == wb_tag) begin
          mq[k].rdy2 = 1; mq[k].op2 = wb_data;
        end
      end
      m_valid = iss || byp;
      if (iss) m_load_out(h);
      else if (byp) m_load_out(ne);
      if (acc && !byp) mq.push_back(ne);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m.valid", o_valid, m_valid);
      chk("m.count", o_count, mq.size());
      chk("m.dis_ready", dis_ready, mq.size() != 8);
      chk("m.uop", o_uop, m_uop);
      chk("m.func", o_func, m_func);
      chk("m.addr", o_addr, m_rd);
      chk("m.op1", o_op1, m_op1);
      chk("m.op2", o_op2, m_op2);
      chk("m.imm", o_imm, m_imm);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; dis_valid = 0; uop = 0; func = 0; rd = 0; rs1 = 0; rs2 = 0;
    rs1_rdy = 0; rs2_rdy = 0; op1 = 0; op2 = 0; imm = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0;
  endtask

  task automatic dis(input logic [6:0] u, input logic [4:0] d, input logic [4:0] s1,
                     input bit r1, input logic [31:0] v1, input logic [4:0] s2,
                     input bit r2, input logic [31:0] v2, input logic [31:0] im);
    dis_valid = 1; uop = u; func = 10'h2; rd = d; rs1 = s1; rs1_rdy = r1; op1 = v1;
    rs2 = s2; rs2_rdy = r2; op2 = v2; imm = im;
  endtask

  task automatic wake(input logic [4:0] t, input logic [31:0] d);
    wb_valid = 1; wb_tag = t; wb_data = d;
  endtask

  logic [31:0] cap[$];

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    cmp_on = 1;
    // Reset state
    chk("rst.valid", o_valid, 0);
    chk("rst.count", o_count, 0);
    chk("rst.dis_ready", dis_ready, 1);
    chk("rst.op1", o_op1, 0);
    chk("rst.addr", o_addr, 0);
    rst_n = 1;

    // Load with ready base
    dis(OPC_LOAD, 5'd7, 5'd1, 1, 32'h100, 5'd0, 1, 32'h0, 32'd4);
    step(); dis_valid = 0;
`ifndef MEMQ_BYPASS_EN
    chk("ld.early", o_valid, 0);
    chk("ld.count1", o_count, 1);
    step();
`endif
    chk("ld.valid", o_valid, 1);
    chk("ld.op1", o_op1, 32'h100);
    chk("ld.imm", o_imm, 4);
    chk("ld.addr", o_addr, 7);
    chk("ld.count0", o_count, 0);
    step();
    chk("ld.pulse", o_valid, 0);

    // Store waiting on data operand
    dis(OPC_STORE, 5'd2, 5'd1, 1, 32'h200, 5'd9, 0, 32'h0, 32'd8);
    step(); dis_valid = 0;
    step();
    chk("st.wait", o_valid, 0);
    wake(5'd9, 32'hDEADBEEF);
    step(); wb_valid = 0;
    chk("st.m1", o_valid, 0);
    step();
    chk("st.valid", o_valid, 1);
    chk("st.op2", o_op2, 32'hDEADBEEF);
    chk("st.uop", o_uop, OPC_STORE);

    // Blocked head keeps a ready younger load waiting
    dis(OPC_STORE, 5'd3, 5'd3, 0, 32'h0, 5'd1, 1, 32'h55, 32'h10);
    step();
    dis(OPC_LOAD, 5'd4, 5'd1, 1, 32'h300, 5'd0, 1, 32'h0, 32'h20);
    step(); dis_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("ord.block", o_valid, 0);
      step();
    end
    wake(5'd3, 32'h1000);
    step(); wb_valid = 0;
    chk("ord.m1", o_valid, 0);
    step();
    chk("ord.st", o_valid, 1);
    chk("ord.st_uop", o_uop, OPC_STORE);
    chk("ord.st_op1", o_op1, 32'h1000);
    step();
    chk("ord.ld", o_valid, 1);
    chk("ord.ld_imm", o_imm, 32'h20);
    step();
    chk("ord.count", o_count, 0);

    // Fill, overflow attempt, drain, refill across wrap
    for (int i = 0; i < 8; i++) begin
      dis(OPC_LOAD, 5'(i), 5'd5, 0, 32'h0, 5'd0, 1, 32'h0, 32'(i));
      step();
    end
    chk("full.count", o_count, 8);
    chk("full.ready", dis_ready, 0);
    dis(OPC_LOAD, 5'd1, 5'd1, 1, 32'h0, 5'd0, 1, 32'h0, 32'd99);
    step(); dis_valid = 0;
    chk("full.ignored", o_count, 8);
    wake(5'd5, 32'hA5);
    step(); wb_valid = 0;
    chk("drain.m1", o_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain.valid", o_valid, 1);
      chk("drain.imm", o_imm, 32'(i));
    end
    step();
    chk("drain.empty", o_count, 0);
    for (int c = 0; c < 8; c++) begin
      if (c < 3) dis(OPC_LOAD, 5'd1, 5'd1, 1, 32'h7, 5'd0, 1, 32'h0, 32'(100 + c));
      else dis_valid = 0;
      step();
      if (o_valid) cap.push_back(o_imm);
    end
    chk("wrap.n", cap.size(), 3);
    for (int j = 0; j < cap.size() && j < 3; j++) chk("wrap.imm", cap[j], 32'(100 + j));

    // Flush while head issues, with a dispatch in the same cycle
    for (int i = 0; i < 5; i++) begin
      dis(OPC_LOAD, 5'd2, 5'd6, 0, 32'h0, 5'd0, 1, 32'h0, 32'(i));
      step();
    end
    dis_valid = 0;
    wake(5'd6, 32'h66);
    step(); wb_valid = 0;
    chk("fl.pre", o_count, 5);
    flush = 1;
    dis(OPC_LOAD, 5'd3, 5'd1, 1, 32'h1, 5'd0, 1, 32'h0, 32'd77);
    step(); flush = 0; dis_valid = 0;
    chk("fl.valid", o_valid, 0);
    chk("fl.count", o_count, 0);
    chk("fl.ready", dis_ready, 1);
    step();
    chk("fl.dropped", o_count, 0);
    chk("fl.valid2", o_valid, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int sel;
      rst_n     = !(c >= 2000 && c < 2002);
      flush     = ($urandom_range(0, 63) == 0);
      dis_valid = ($urandom_range(0, 9) < 6);
      sel       = $urandom_range(0, 4);
      uop       = (sel < 2) ? OPC_LOAD : (sel < 4) ? OPC_STORE : 7'b0010011;
      func      = 10'($urandom);
      rd        = 5'($urandom);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      rs1_rdy   = ($urandom_range(0, 2) == 0);
      rs2_rdy   = ($urandom_range(0, 2) == 0);
      op1       = $urandom;
      op2       = $urandom;
      imm       = $urandom;
      wb_valid  = $urandom_range(0, 1);
      wb_tag    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      step();
    end
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
